// File: rtl/cursor_controller.sv
// cursor_controller: debounced buttons to board cursor with hold-to-repeat and select capture.
// Define CURSOR_WRAP_EN to make moves past a board edge wrap instead of clamp.
module cursor_controller #(
   parameter int COLS         = 8,
   parameter int ROWS         = 8,
   parameter int X_W          = 3,
   parameter int Y_W          = 3,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000,
   parameter int CNT_W        = 27
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           up_in,
   input  logic           right_in,
   input  logic           down_in,
   input  logic           left_in,
   input  logic           s_in,
   output logic [X_W-1:0] cur_x,
   output logic [Y_W-1:0] cur_y,
   output logic           move_pulse,
   output logic           sel_pulse,
   output logic [X_W-1:0] sel_x,
   output logic [Y_W-1:0] sel_y
);
`ifdef CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam logic [X_W-1:0]   X_MAX  = X_W'(COLS - 1);
   localparam logic [Y_W-1:0]   Y_MAX  = Y_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_END = CNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       s1_q, s2_q, p_q;
   logic [X_W-1:0]   cur_x_q, cur_x_d, sel_x_q, sel_x_d, step_x;
   logic [Y_W-1:0]   cur_y_q, cur_y_d, sel_y_q, sel_y_d, step_y;
   logic             move_pulse_q, move_pulse_d, sel_pulse_q, sel_pulse_d;
   logic [4:0]       rise;
   logic [3:0]       d, d_prev;
   logic             single, do_move, sel_ev;

   // bit order {up, right, down, left, select}
   assign rise   = s2_q & ~p_q;
   assign d      = s2_q[4:1];
   assign d_prev = p_q[4:1];
   assign single = (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
   assign sel_ev = en && rise[0];

   always_comb begin
      step_x = cur_x_q;
      step_y = cur_y_q;
      if (d[2]) step_x = (cur_x_q == X_MAX) ? (WRAP ? '0 : X_MAX) : cur_x_q + 1'b1;
      if (d[0]) step_x = (cur_x_q == '0) ? (WRAP ? X_MAX : '0) : cur_x_q - 1'b1;
      if (d[1]) step_y = (cur_y_q == Y_MAX) ? (WRAP ? '0 : Y_MAX) : cur_y_q + 1'b1;
      if (d[3]) step_y = (cur_y_q == '0) ? (WRAP ? Y_MAX : '0) : cur_y_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_move = 1'b0;
      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (|rise[4:1] && single) begin
               do_move = 1'b1;
               cnt_d   = '0;
               state_d = HOLD;
            end
            HOLD, REPEAT: if (d != d_prev) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == ((state_q == HOLD) ? DLY_END : RPT_END)) begin
               do_move = 1'b1;
               cnt_d   = '0;
               state_d = REPEAT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      cur_x_d      = do_move ? step_x : cur_x_q;
      cur_y_d      = do_move ? step_y : cur_y_q;
      move_pulse_d = do_move && (WRAP || step_x != cur_x_q || step_y != cur_y_q);
      sel_x_d      = sel_ev ? cur_x_q : sel_x_q;
      sel_y_d      = sel_ev ? cur_y_q : sel_y_q;
      sel_pulse_d  = sel_ev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         s1_q         <= '0;
         s2_q         <= '0;
         p_q          <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         sel_x_q      <= '0;
         sel_y_q      <= '0;
         move_pulse_q <= 1'b0;
         sel_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         s1_q         <= {up_in, right_in, down_in, left_in, s_in};
         s2_q         <= s1_q;
         p_q          <= s2_q;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         sel_x_q      <= sel_x_d;
         sel_y_q      <= sel_y_d;
         move_pulse_q <= move_pulse_d;
         sel_pulse_q  <= sel_pulse_d;
      end
   end

   assign cur_x      = cur_x_q;
   assign cur_y      = cur_y_q;
   assign move_pulse = move_pulse_q;
   assign sel_pulse  = sel_pulse_q;
   assign sel_x      = sel_x_q;
   assign sel_y      = sel_y_q;
endmodule

// File: tb/tb_cursor_controller.sv
// tb_cursor_controller: directed and random button stimulus against a behavioural cursor model.
module tb_cursor_controller;
   localparam int COLS = 4, ROWS = 3, XW = 2, YW = 2, DLY = 10, RATE = 4, CW = 8;
`ifdef CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam logic [4:0] UP = 5'b10000, RIGHT = 5'b01000, DOWN = 5'b00100, LEFT = 5'b00010, SEL = 5'b00001;

   logic          clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic [4:0]    btn = '0;
   logic [XW-1:0] cur_x, sel_x;
   logic [YW-1:0] cur_y, sel_y;
   logic          move_pulse, sel_pulse;

   cursor_controller #(.COLS(COLS), .ROWS(ROWS), .X_W(XW), .Y_W(YW),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .up_in(btn[4]), .right_in(btn[3]), .down_in(btn[2]), .left_in(btn[1]), .s_in(btn[0]),
      .cur_x(cur_x), .cur_y(cur_y), .move_pulse(move_pulse),
      .sel_pulse(sel_pulse), .sel_x(sel_x), .sel_y(sel_y));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Model: buttons seen by the cursor logic are the raw inputs two edges old.
   logic [4:0] h1, h2, h3;
   logic [3:0] dv, dp;
   int  mx, my, msx, msy, nx, ny, t;
   bit  mmp, msp, active, mv, started = 0;

   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         h1 = '0; h2 = '0; h3 = '0;
         mx = 0; my = 0; msx = 0; msy = 0; mmp = 0; msp = 0; active = 0; t = 0;
      end else begin
         dv = h2[4:1]; dp = h3[4:1]; mv = 0; mmp = 0; msp = 0;
         if (!en) active = 0;
         else begin
            if (!active) begin
               if ((dv & ~dp) != 0 && $countones(dv) == 1) begin mv = 1; active = 1; t = 0; end
            end else if (dv != dp) active = 0;
            else begin
               t++;
               mv = (t == DLY) || (t > DLY && (t - DLY) % RATE == 0);
            end
            if (h2[0] && !h3[0]) begin msx = mx; msy = my; msp = 1; end
            if (mv) begin
               nx = mx + (dv[2] ? 1 : 0) - (dv[0] ? 1 : 0);
               ny = my + (dv[1] ? 1 : 0) - (dv[3] ? 1 : 0);
               nx = WRAP ? (nx + COLS) % COLS : (nx < 0 ? 0 : nx > COLS - 1 ? COLS - 1 : nx);
               ny = WRAP ? (ny + ROWS) % ROWS : (ny < 0 ? 0 : ny > ROWS - 1 ? ROWS - 1 : ny);
               mmp = WRAP || nx != mx || ny != my;
               mx = nx; my = ny;
            end
         end
         h3 = h2; h2 = h1; h1 = btn;
      end
   end

   always @(negedge clk) if (started) begin
      check("cur_x", 32'(cur_x), 32'(mx));
      check("cur_y", 32'(cur_y), 32'(my));
      check("move_pulse", 32'(move_pulse), 32'(mmp));
      check("sel_pulse", 32'(sel_pulse), 32'(msp));
      check("sel_x", 32'(sel_x), 32'(msx));
      check("sel_y", 32'(sel_y), 32'(msy));
   end

   task automatic drive(input logic [4:0] b, input int n);
      btn = b;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int r;
      logic [4:0] pats [8];
      pats[0] = UP; pats[1] = RIGHT; pats[2] = DOWN; pats[3] = LEFT;
      pats[4] = SEL; pats[5] = RIGHT | SEL; pats[6] = UP | LEFT; pats[7] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(RIGHT, 3); drive('0, 5);
      drive(DOWN, 40); drive('0, 3);
      drive(RIGHT, 30); drive('0, 3);
      drive(UP | LEFT, 5); drive(LEFT, 8); drive('0, 3);
      drive(SEL, 2); drive('0, 3);
      drive(LEFT, 3); drive('0, 3);
      drive(RIGHT | SEL, 3); drive('0, 3);
      drive(LEFT, 3); drive('0, 3);
      drive(RIGHT, 5); en = 1'b0; drive(RIGHT, 20); en = 1'b1; drive(RIGHT, 20);
      drive('0, 3); drive(RIGHT, 5);
      rst = 1'b1; drive(RIGHT, 3); rst = 1'b0; drive(RIGHT, 6); drive('0, 3);
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         en = (r >= 4);
         rst = (r == 99);
         drive(pats[$urandom_range(0, 7)], $urandom_range(1, 25));
         rst = 1'b0;
         if (r < 30) drive('0, $urandom_range(1, 4));
      end
      en = 1'b1;
      drive('0, 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cursor_controller.md
Name: cursor_controller

Overview:
- Sits directly downstream of the button debounce/input stage.
- Consumes the five debounced button levels (up/right/down/left/select) and turns them into game-board cursor motion with hold-to-repeat.
- Emits a one-cycle select event carrying the cursor coordinates, for the tile-matching logic.
- Runs entirely on the system clock. Inputs arrive from the slow debounce clock domain and are resynchronised here.

Parameters:
- COLS, 8, board width in tiles.
- ROWS, 8, board height in tiles.
- X_W, 3, width of column coordinate; must satisfy 2^X_W >= COLS.
- Y_W, 3, width of row coordinate; must satisfy 2^Y_W >= ROWS.
- REPEAT_DELAY, 50000000, clk cycles from the first move to the first auto-repeat move.
- REPEAT_RATE, 10000000, clk cycles between subsequent auto-repeat moves.
- CNT_W, 27, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  block enable
- up_in  input  1  debounced up level
- right_in  input  1  debounced right level
- down_in  input  1  debounced down level
- left_in  input  1  debounced left level
- s_in  input  1  debounced select level
- cur_x  output  X_W  cursor column, 0..COLS-1
- cur_y  output  Y_W  cursor row, 0..ROWS-1 (0 = top)
- move_pulse  output  1  one-cycle strobe, high in the cycle after cur_x/cur_y changes
- sel_pulse  output  1  one-cycle select strobe
- sel_x  output  X_W  column captured at select
- sel_y  output  Y_W  row captured at select

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: cur_x=0, cur_y=0, move_pulse=0, sel_pulse=0, sel_x=0, sel_y=0, FSM=IDLE, counter=0, all sync/previous-value registers=0.
- Synchronisation: each input passes through a 2-flop synchroniser (s1, s2) plus a previous-value register (p). rise = s2 & ~p. Sync and p registers update every cycle regardless of en.
- Latency: an input high before edge k gives a move committed at edge k+2. cur_x/cur_y change at edge k+2; move_pulse is high for the cycle after k+2.
- Direction vector d = {up,right,down,left} taken from s2. "Single" means exactly one bit of d is set.
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - rise on a direction while d is single → move one step, counter=0, go to HOLD.
  - rise while d is not single (simultaneous press) → no move, stay IDLE.
- HOLD:
  - d unchanged → counter increments; at counter == REPEAT_DELAY-1, move, counter=0, go to REPEAT.
  - d changes in any way (release, extra press) → IDLE, no move.
- REPEAT:
  - Same as HOLD, but moves every REPEAT_RATE cycles and stays in REPEAT.
  - Any change in d → IDLE, no move.
- Net result of these rules: pressing right while holding up gives no move; releasing up afterwards also gives no move (right has no new rise).
- Movement: up decrements y, down increments y, left decrements x, right increments x.
- Edge clamp (macro absent): at the board edge the coordinate holds; move_pulse is still not asserted because no change occurred.
- Select: rise on s → sel_x/sel_y capture the current cur_x/cur_y and sel_pulse=1 for exactly one cycle.
- Select is independent of the direction FSM. If a move and a select commit on the same edge, sel_x/sel_y take the pre-move coordinates.
- Enable low:
  - FSM forced to IDLE, counter=0.
  - No moves; move_pulse=0, sel_pulse=0; cur/sel outputs hold.
  - Buttons held across re-enable do not act until released and re-pressed.
- Reset mid-hold: sync registers clear, so a button still held after rst deasserts produces a fresh rise and exactly one move, 2 edges after reset release.
- Arithmetic: coordinates are unsigned. Comparisons use COLS-1 / ROWS-1, never 2^W wrap.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moving past an edge wraps (x=COLS-1 + right → 0; x=0 + left → COLS-1; same for y with ROWS). Every commanded move produces move_pulse.
- Not defined: edge clamp as described in Behaviour.

Test Plan (COLS=4, ROWS=3, REPEAT_DELAY=10, REPEAT_RATE=4 unless stated):
- Reset, then pulse right_in high for 3 cycles → cur_x=1 after edge 2 of the press; move_pulse exactly one cycle; cur_y=0.
- Hold down_in 40 cycles from (0,0), clamp build → y=1 at press+2, y=2 at +10 cycles, then stays 2; exactly 2 move_pulses.
- Hold right_in 30 cycles → x steps at press+2, +10, +14, +18 → clamps at 3; with CURSOR_WRAP_EN the sequence is 1,2,3,0,1,2,... every 4 cycles after the first repeat.
- Press up_in and left_in on the same cycle → no move, no move_pulse; release up while left stays held → still no move.
- At cursor (2,1), pulse s_in → sel_pulse one cycle, sel_x=2, sel_y=1. Select coincident with a right move → sel_x=2 while cur_x becomes 3.
- Hold right_in, drop en for 20 cycles, raise it again with right still held → no movement until right is released and re-pressed. Assert rst mid-hold → outputs zero; one move fires 2 edges after rst release.
